tcdm_rr_bank_slave: RTL and testbench
=====================================

TCDM_RR_BANK_SLAVE -- requirements
Module: tcdm_rr_bank_slave

Interface
REQ-001 SHALL have parameter MP, default 4, number of TCDM slave ports served.
REQ-002 SHALL have parameter NWORDS, default 1024, bank depth in 32-bit words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-004 SHALL have port clk_i  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall_i  input  1  when 1, no grant issued this cycle.
REQ-007 SHALL have port tcdm_req  input  [MP-1:0]  per-port request.
REQ-008 SHALL have port tcdm_gnt  output  [MP-1:0]  per-port grant, combinational.
REQ-009 SHALL have port tcdm_add  input  [MP-1:0][31:0]  byte address.
REQ-010 SHALL have port tcdm_wen  input  [MP-1:0]  1 = read, 0 = write.
REQ-011 SHALL have port tcdm_be  input  [MP-1:0][3:0]  byte enables for writes.
REQ-012 SHALL have port tcdm_data  input  [MP-1:0][31:0]  write data.
REQ-013 SHALL have port tcdm_r_data  output  [MP-1:0][31:0]  response data, registered.
REQ-014 SHALL have port tcdm_r_valid  output  [MP-1:0]  response strobe, registered.

Function
REQ-015 SHALL grant at most one port per cycle, and only when stall_i=0.
REQ-016 SHALL raise tcdm_gnt[i] in the same cycle as tcdm_req[i] when port i wins arbitration.
REQ-017 SHALL arbitrate round-robin: priority pointer P starts at port 0; search order is P, P+1, ..., wrapping modulo MP.
REQ-018 SHALL set P to (g+1) mod MP after a grant to port g; P SHALL be unchanged in cycles with no grant.
REQ-019 SHALL leave req-held-until-gnt to the masters; a request not granted SHALL stay pending with no side effect.
REQ-020 SHALL compute word index = ((add - BASE_ADDR) >> 2) mod NWORDS; out-of-window addresses wrap and are not flagged.
REQ-021 SHALL, on a granted write, update only the bytes with be=1 at the clock edge of the grant cycle.
REQ-022 SHALL, on a granted read, assert tcdm_r_valid[g] for exactly one cycle, in the cycle after the grant, with tcdm_r_data[g] = word contents before any write in the grant cycle.
REQ-023 SHALL, on a granted write, assert tcdm_r_valid[g] for one cycle in the cycle after the grant, with tcdm_r_data[g]=32'h0.
REQ-024 SHALL hold tcdm_r_data[i] until port i's next response; tcdm_r_valid[i] SHALL be 0 in all other cycles.
REQ-025 SHALL sustain one transaction per cycle: back-to-back grants to the same or different ports with no bubble.
REQ-026 SHALL make a read granted in the cycle after a write to the same word return the newly written data.
REQ-027 SHALL, when stall_i=1, drive tcdm_gnt=0 regardless of requests; responses to grants from the previous cycle SHALL still be delivered.

Reset
REQ-028 SHALL on rst_ni=0 asynchronously set P=0, tcdm_r_valid=0, and tcdm_r_data=0 on all ports.
REQ-029 SHALL NOT reset memory contents; contents after reset are undefined.
REQ-030 SHALL, when reset asserts in the cycle after a grant, drop that response (no r_valid after reset release); the first grant after release SHALL go to the lowest requesting index.

Verification
REQ-031 Single write then read: port 0 writes 32'hA5A5_1234 (be=4'hF) to BASE_ADDR+8; port 0 then reads BASE_ADDR+8 -> read r_valid[0] one cycle after its gnt with r_data=32'hA5A5_1234; write response has r_data=0.
REQ-032 Partial write: word 32'h1111_1111; write be=4'b0101, data 32'hAABB_CCDD; read back -> 32'h11BB_11DD.
REQ-033 Fairness: all 4 ports hold req continuously from reset -> grants in order 0,1,2,3,0,1,...; each port gets exactly 1 grant per 4 cycles; one r_valid per cycle.
REQ-034 Stall: all ports requesting, stall_i=1 for 3 cycles -> no gnt, P unchanged; the response from the grant just before the stall still arrives.
REQ-035 Wrap: NWORDS=1024; write 32'hCAFE_0001 to BASE_ADDR+4096, read BASE_ADDR+0 -> 32'hCAFE_0001.
REQ-036 Reset mid-operation: grant port 2 read, assert rst_ni=0 next cycle -> r_valid all 0; after release with ports 1 and 3 requesting -> port 1 granted first.

Source files
------------

// File: rtl/tcdm_rr_bank_slave.sv
// Single-bank TCDM slave shared by MP ports through a round-robin arbiter.
// One transaction per cycle; reads return pre-write data one cycle after grant.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   stall_i            suppresses all grants this cycle
//   tcdm_req/gnt       per-port request / combinational grant
//   tcdm_add/wen/be/data  per-port byte address, 1=read, byte enables, write data
//   tcdm_r_data/r_valid   per-port registered response data and strobe
module tcdm_rr_bank_slave #(
  parameter int unsigned MP        = 4,
  parameter int unsigned NWORDS    = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid
);

  localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_c;
  logic          any_c;
  logic [31:0]   offs_c;
  logic [AW-1:0] widx_c;
  logic [31:0]   rsp_c;
  logic [31:0]   mem [NWORDS];
  logic          unused_c;

  // Round-robin search starting at ptr, wrapping modulo MP.
  always_comb begin : arb
    int unsigned idx;
    any_c    = 1'b0;
    win_c    = '0;
    tcdm_gnt = '0;
    idx      = 0;
    for (int unsigned k = 0; k < MP; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= MP) idx = idx - MP;
      if (!any_c && tcdm_req[PW'(idx)]) begin
        any_c = 1'b1;
        win_c = PW'(idx);
      end
    end
    if (stall_i) any_c = 1'b0;
    if (any_c) tcdm_gnt[win_c] = 1'b1;
  end

  // Word index of the winning port; out-of-window addresses simply wrap.
  always_comb begin : addr
    offs_c = tcdm_add[win_c] - BASE_ADDR;
    widx_c = offs_c[AW+1:2];
    rsp_c  = tcdm_wen[win_c] ? mem[widx_c] : 32'h0;
  end

  assign unused_c = ^{offs_c[31:AW+2], offs_c[1:0]};

  // Bank storage: byte-masked write, intentionally not reset.
  always_ff @(posedge clk_i) begin : bank
    if (any_c && !tcdm_wen[win_c]) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm_be[win_c][b]) mem[widx_c][8*b +: 8] <= tcdm_data[win_c][8*b +: 8];
      end
    end
  end

  // Priority pointer and per-port response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin : rsp
    if (!rst_ni) begin
      ptr          <= '0;
      tcdm_r_valid <= '0;
      tcdm_r_data  <= '0;
    end else begin
      tcdm_r_valid <= tcdm_gnt;
      if (any_c) begin
        ptr                <= (win_c == PW'(MP-1)) ? '0 : win_c + PW'(1);
        tcdm_r_data[win_c] <= rsp_c;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_rr_bank_slave.sv
// Directed bench for tcdm_rr_bank_slave: vector table plus stall/fairness/reset sequences.
module tb_tcdm_rr_bank_slave;

  localparam int unsigned MP     = 4;
  localparam int unsigned NWORDS = 1024;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          NV     = 11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall;
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] wdata;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic        stall;
    logic [3:0]  wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  tcdm_rr_bank_slave #(.MP(MP), .NWORDS(NWORDS), .BASE_ADDR(BASE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stall_i      (stall),
    .tcdm_req     (req),
    .tcdm_gnt     (gnt),
    .tcdm_add     (add),
    .tcdm_wen     (wen),
    .tcdm_be      (be),
    .tcdm_data    (wdata),
    .tcdm_r_data  (r_data),
    .tcdm_r_valid (r_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All ports see the same address/be/data; req, wen select behaviour.
  task automatic drive(input logic [3:0] r, input logic s, input logic [3:0] w,
                       input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req   = r;
    stall = s;
    wen   = w;
    for (int p = 0; p < MP; p++) begin
      add[p]   = a;
      be[p]    = b;
      wdata[p] = d;
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 4'b0000, BASE + 32'd8,    4'hF,    32'hA5A5_1234, 4'b0001, 32'h0};
    vecs[1]  = '{4'b0001, 1'b0, 4'b1111, BASE + 32'd8,    4'hF,    32'h0,         4'b0001, 32'hA5A5_1234};
    vecs[2]  = '{4'b0010, 1'b0, 4'b0000, BASE + 32'd16,   4'hF,    32'h1111_1111, 4'b0010, 32'h0};
    vecs[3]  = '{4'b0010, 1'b0, 4'b0000, BASE + 32'd16,   4'b0101, 32'hAABB_CCDD, 4'b0010, 32'h0};
    vecs[4]  = '{4'b0010, 1'b0, 4'b1111, BASE + 32'd16,   4'hF,    32'h0,         4'b0010, 32'h11BB_11DD};
    vecs[5]  = '{4'b1000, 1'b0, 4'b0000, BASE + 32'd4096, 4'hF,    32'hCAFE_0001, 4'b1000, 32'h0};
    vecs[6]  = '{4'b1000, 1'b0, 4'b1111, BASE,            4'hF,    32'h0,         4'b1000, 32'hCAFE_0001};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1111, BASE,            4'hF,    32'h0,         4'b0000, 32'h0};
    vecs[8]  = '{4'b0110, 1'b0, 4'b1111, BASE,            4'hF,    32'h0,         4'b0010, 32'hCAFE_0001};
    vecs[9]  = '{4'b0110, 1'b0, 4'b1111, BASE,            4'hF,    32'h0,         4'b0100, 32'hCAFE_0001};
    vecs[10] = '{4'b0011, 1'b0, 4'b1111, BASE,            4'hF,    32'h0,         4'b0001, 32'hCAFE_0001};

    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000, BASE, 4'h0, 32'h0);
    #1;
    chk("reset_rvalid", 32'(r_valid), 32'h0);
    for (int p = 0; p < MP; p++) chk($sformatf("reset_rdata%0d", p), r_data[p], 32'h0);
    chk("idle_gnt", 32'(gnt), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: each row is one cycle; response checked just after its edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].stall, vecs[i].wen, vecs[i].add, vecs[i].be, vecs[i].data);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rvalid", i), 32'(r_valid), 32'(vecs[i].exp_gnt));
      for (int p = 0; p < MP; p++)
        if (vecs[i].exp_gnt[p]) chk($sformatf("v%0d_rdata%0d", i, p), r_data[p], vecs[i].exp_rd);
    end
    // Ports 1 and 2 keep their last response data.
    chk("hold_rdata1", r_data[1], 32'hCAFE_0001);
    chk("hold_rdata2", r_data[2], 32'hCAFE_0001);

    // Fairness from reset with all ports requesting.
    @(negedge clk);
    drive(4'b0000, 1'b0, 4'b1111, BASE, 4'hF, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(4'b1111, 1'b0, 4'b1111, BASE, 4'hF, 32'h0);
      #1;
      chk($sformatf("rr%0d_gnt", c), 32'(gnt), 32'(1) << (c % 4));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_rvalid", c), 32'(r_valid), 32'(1) << (c % 4));
    end

    // Grant to port 0, then three stalled cycles: pending response still lands.
    @(negedge clk);
    #1;
    chk("pre_stall_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      chk($sformatf("stall%0d_gnt", c), 32'(gnt), 32'h0);
      chk($sformatf("stall%0d_rvalid", c), 32'(r_valid), (c == 0) ? 32'h1 : 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("post_stall_gnt", 32'(gnt), 32'h2);
    chk("post_stall_rvalid", 32'(r_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("post_stall_rsp", 32'(r_valid), 32'h2);

    // Reset right after a port-2 read grant drops its response.
    @(negedge clk);
    drive(4'b0100, 1'b0, 4'b1111, BASE, 4'hF, 32'h0);
    #1;
    chk("p2_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(r_valid), 32'h0);
    chk("midrst_rdata2", r_data[2], 32'h0);
    @(negedge clk);
    drive(4'b1010, 1'b0, 4'b1111, BASE, 4'hF, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rvalid", 32'(r_valid), 32'h0);
    chk("rel_gnt", 32'(gnt), 32'h2);
    @(posedge clk);
    #1;
    chk("rel_rsp", 32'(r_valid), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
